// File: rtl/mem_responder_pkg.sv
// Shared types and helpers for the memory-side read responder.
package mem_responder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Latency counter width: max(1, $clog2(latency)).
  function automatic int cnt_width(input int latency);
    int w;
    w = $clog2(latency);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_responder_store.sv
// Word storage with a reset pattern of mem[i] = i and a combinational read port.
// MEM_RESPONDER_WR_EN adds a synchronous preload write port; without it the array is a ROM.
module mem_responder_store
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
`ifdef MEM_RESPONDER_WR_EN
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`endif
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_oob
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

  assign rd_oob = ({1'b0, rd_addr} >= DEPTH_W);

`ifdef MEM_RESPONDER_WR_EN
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  wr_oob;

  assign wr_oob = ({1'b0, wr_addr} >= DEPTH_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= DATA_WIDTH'(i);
      end
    end else if (wr_en && !wr_oob) begin
      mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_oob ? '0 : mem[rd_addr[IDX_W-1:0]];
`else
  assign rd_data = rd_oob ? '0 : DATA_WIDTH'(rd_addr);
`endif

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency read responder: accepts init+addr, holds mem_busy for LATENCY cycles, returns one word.
// Optional preload write port enabled by defining MEM_RESPONDER_WR_EN.
//
// Handshake: a request is accepted on a rising edge where init=1 and state is IDLE (mem_busy=0);
// init is ignored while mem_busy=1. data_valid (and err for out-of-range) pulse for exactly one
// cycle in the cycle after mem_busy falls; data_out holds until the next completion.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic [ADDR_WIDTH-1:0] addr,
`ifdef MEM_RESPONDER_WR_EN
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
`endif
  output logic                  mem_busy,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  err,
  output state_t                state_dbg
);

  localparam int             CW       = cnt_width(LATENCY);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(LATENCY - 1);

  state_t                state;
  state_t                next_state;
  logic                  accept;
  logic                  complete;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_oob;

  mem_responder_store #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_store (
`ifdef MEM_RESPONDER_WR_EN
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
`endif
    .rd_addr (addr_q),
    .rd_data (rd_data),
    .rd_oob  (rd_oob)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (init) begin
          accept     = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign mem_busy  = (state == BUSY);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      data_valid <= complete;
      err        <= complete && rd_oob;
      if (accept) begin
        addr_q <= addr;
        cnt    <= CNT_LOAD;
      end else if (mem_busy && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      // Read happens before any same-edge write lands in the store.
      if (complete) begin
        data_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters, LATENCY=2, DEPTH=64).
// Write-port cases are included when MEM_RESPONDER_WR_EN is defined.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic          clk;
  logic          rst;
  logic          init;
  logic [AW-1:0] addr;
  logic          mem_busy;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          err;
  state_t        state_dbg;
`ifdef MEM_RESPONDER_WR_EN
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
`endif

  int n_total;
  int n_bad;

  mem_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (64),
    .LATENCY    (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init       (init),
    .addr       (addr),
`ifdef MEM_RESPONDER_WR_EN
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
`endif
    .mem_busy   (mem_busy),
    .data_out   (data_out),
    .data_valid (data_valid),
    .err        (err),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one read and follow it to completion with a bounded wait.
  task automatic read_word(input string tag, input logic [AW-1:0] a,
                           input logic [DW-1:0] exp_d, input logic exp_e);
    int busy_n;
    int guard;
    init = 1'b1;
    addr = a;
    tick();
    init   = 1'b0;
    addr   = 8'($urandom_range(0, 255));
    busy_n = 0;
    guard  = 0;
    while (!data_valid && guard < 20) begin
      if (mem_busy) busy_n++;
      tick();
      guard++;
    end
    check({tag, "_valid"}, 32'(data_valid), 32'd1);
    check({tag, "_busy_cycles"}, busy_n, LAT);
    check({tag, "_busy_at_valid"}, 32'(mem_busy), 32'd0);
    check({tag, "_data"}, 32'(data_out), 32'(exp_d));
    check({tag, "_err"}, 32'(err), 32'(exp_e));
    tick();
    check({tag, "_valid_pulse"}, 32'(data_valid), 32'd0);
    check({tag, "_data_hold"}, 32'(data_out), 32'(exp_d));
  endtask

`ifdef MEM_RESPONDER_WR_EN
  task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
`endif

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b0;
    init    = 1'b0;
    addr    = '0;
`ifdef MEM_RESPONDER_WR_EN
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`endif

    // reset then idle
    tick();
    tick();
    check("rst_busy", 32'(mem_busy), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", 32'(mem_busy), 32'd0);
      check("idle_valid", 32'(data_valid), 32'd0);
    end

    // single reads, including range boundaries
    read_word("rd05", 8'h05, 8'h05, 1'b0);
    read_word("rd3f", 8'h3f, 8'h3f, 1'b0);
    read_word("rd40", 8'h40, 8'h00, 1'b1);
    read_word("rdff", 8'hff, 8'h00, 1'b1);
    read_word("rd00", 8'h00, 8'h00, 1'b0);

    // back-to-back with init held high
    init = 1'b1;
    addr = 8'h10;
    tick();
    check("b2b_busy0", 32'(mem_busy), 32'd1);
    addr = 8'h11;
    tick();
    check("b2b_busy1", 32'(mem_busy), 32'd1);
    check("b2b_novalid", 32'(data_valid), 32'd0);
    tick();
    check("b2b_valid1", 32'(data_valid), 32'd1);
    check("b2b_data1", 32'(data_out), 32'h10);
    check("b2b_busy_at_v1", 32'(mem_busy), 32'd0);
    tick();
    init = 1'b0;
    addr = 8'h22;
    check("b2b_busy2", 32'(mem_busy), 32'd1);
    check("b2b_v_gap1", 32'(data_valid), 32'd0);
    tick();
    check("b2b_v_gap2", 32'(data_valid), 32'd0);
    tick();
    check("b2b_valid2", 32'(data_valid), 32'd1);
    check("b2b_data2", 32'(data_out), 32'h11);
    check("b2b_err2", 32'(err), 32'd0);
    tick();
    check("b2b_end", 32'(data_valid), 32'd0);

    // reset mid-operation
    init = 1'b1;
    addr = 8'h20;
    tick();
    init = 1'b0;
    check("abort_busy_pre", 32'(mem_busy), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_busy", 32'(mem_busy), 32'd0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_novalid", 32'(data_valid), 32'd0);
    end
    check("abort_data", 32'(data_out), 32'd0);
    read_word("rd03", 8'h03, 8'h03, 1'b0);

`ifdef MEM_RESPONDER_WR_EN
    write_word(8'h07, 8'hab);
    read_word("wr07", 8'h07, 8'hab, 1'b0);
    // same-edge write at completion: old word returned
    init = 1'b1;
    addr = 8'h07;
    tick();
    init = 1'b0;
    tick();
    wr_en   = 1'b1;
    wr_addr = 8'h07;
    wr_data = 8'hcd;
    tick();
    wr_en = 1'b0;
    check("rbw_valid", 32'(data_valid), 32'd1);
    check("rbw_data", 32'(data_out), 32'hab);
    read_word("rbw_next", 8'h07, 8'hcd, 1'b0);
    // write during BUSY, before completion, is visible
    init = 1'b1;
    addr = 8'h08;
    tick();
    init    = 1'b0;
    wr_en   = 1'b1;
    wr_addr = 8'h08;
    wr_data = 8'h5a;
    tick();
    wr_en = 1'b0;
    tick();
    check("wbusy_valid", 32'(data_valid), 32'd1);
    check("wbusy_data", 32'(data_out), 32'h5a);
    write_word(8'h40, 8'h77);
    read_word("wr_oob", 8'h40, 8'h00, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
